// File: rtl/tracer_pkg.sv
// Shared types for the vector-ASIP store tracer: capture filter modes and the
// {addr,data} trace entry layout as seen by the host dump path.
package tracer_pkg;

  localparam int TR_ADDR_W = 16;
  localparam int TR_DATA_W = 48;

  typedef enum logic [1:0] {
    TR_ALL     = 2'd0,
    TR_NONZERO = 2'd1,
    TR_CHANGE  = 2'd2,
    TR_ADDR0   = 2'd3
  } tr_mode_e;

  // Entry layout at the default widths; address occupies the MSBs.
  typedef struct packed {
    logic [TR_ADDR_W-1:0] addr;
    logic [TR_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with registered storage, occupancy count and full/empty flags.
// The caller guarantees push only when a slot is free (or freed by a same-cycle pop).
module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: storage is deliberately not reset; empty masks stale contents on head.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/vec_store_tracer.sv
// Captures data-memory store events through a selectable filter into a FIFO and
// drains them over valid/ready; stores that find the FIFO full are counted.
module vec_store_tracer
  import tracer_pkg::*;
#(
  parameter int ADDR_W = TR_ADDR_W,
  parameter int DATA_W = TR_DATA_W,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      st_valid,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [DATA_W-1:0]         st_data,
  input  logic                      cap_en,
  input  logic [1:0]                mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W+DATA_W-1:0]  out_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic [DROP_W-1:0]         drop_cnt
);

  localparam int ENT_W = ADDR_W + DATA_W;

  tr_mode_e         mode_e;
  logic [ENT_W-1:0] entry;
  logic [ENT_W-1:0] last_cap;
  logic             filter_pass;
  logic             cand;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_empty;

  assign mode_e = tr_mode_e'(mode);
  assign entry  = {st_addr, st_data};

  // NOTE: default assigned first so no path through the case can infer a latch.
  always_comb begin
    filter_pass = 1'b0;
    case (mode_e)
      TR_ALL:     filter_pass = 1'b1;
      TR_NONZERO: filter_pass = (st_addr != '0) && (st_data != '0);
      TR_CHANGE:  filter_pass = (entry != last_cap);
      TR_ADDR0:   filter_pass = (st_addr == '0);
      default:    filter_pass = 1'b0;
    endcase
  end

  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign cand      = st_valid & cap_en & filter_pass;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign push      = cand & (~full | pop);
  assign drop      = cand & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cap <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) last_cap <= entry;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  trace_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (entry),
    .pop       (pop),
    .head      (out_data),
    .level     (level),
    .full      (full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_vec_store_tracer.sv
// Directed bench for vec_store_tracer (DEPTH=4): stimulus pushes expected entries
// into a scoreboard queue; a monitor compares them against each handshake pop.
module tb_vec_store_tracer;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 48;
  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;
  localparam int ENT_W  = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              cap_en;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [ENT_W-1:0]  out_data;
  logic [2:0]        level;
  logic              full;
  logic [DROP_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [ENT_W-1:0] sb [$];

  vec_store_tracer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .cap_en    (cap_en),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .full      (full),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got 0x%0h expected none at %0t", out_data, $time);
      end else begin
        check("pop_data", out_data, sb.pop_front());
      end
    end
  end

  // Drive one store for one cycle; called and returns at posedge+1.
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit exp);
    st_addr  = a;
    st_data  = d;
    st_valid = 1'b1;
    if (exp) sb.push_back({a, d});
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((level != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, 64'(level), 64'd0);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    cap_en = 1'b1; mode = 2'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);

    // 1: mode ALL, three stores, no same-cycle bypass
    out_ready = 1'b1;
    st_addr = 16'h10; st_data = 48'd5; st_valid = 1'b1; sb.push_back({16'h10, 48'd5});
    #3 check("t1_no_bypass", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("t1_valid_next", 64'(out_valid), 64'd1);
    st_addr = 16'h11; st_data = 48'd6; sb.push_back({16'h11, 48'd6});
    @(posedge clk); #1;
    st_valid = 1'b0;
    issue(16'h12, 48'd7, 1'b1);
    wait_drained("t1");

    // 2: mode NONZERO
    mode = 2'd1;
    issue(16'h0, 48'd9, 1'b0);
    issue(16'h4, 48'd0, 1'b0);
    issue(16'h4, 48'd9, 1'b1);
    wait_drained("t2");
    check("t2_drop", 64'(drop_cnt), 64'd0);

    // 3: fill with out_ready=0, two drops
    mode = 2'd0; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(16'h20 + 16'(i), 48'h100 + 48'(i), i < 4);
      if (i == 3) check("t3_full_after4", 64'(full), 64'd1);
      if (i == 2) check("t3_not_full_after3", 64'(full), 64'd0);
    end
    check("t3_drop", 64'(drop_cnt), 64'd2);
    check("t3_level", 64'(level), 64'd4);
    check("t3_head_stable", out_data, {16'h20, 48'h100});

    // 4: full FIFO, push with simultaneous pop is accepted
    out_ready = 1'b1;
    issue(16'h30, 48'hABC, 1'b1);
    check("t4_level", 64'(level), 64'd4);
    check("t4_drop", 64'(drop_cnt), 64'd2);
    wait_drained("t34");

    // 5: mode CHANGE
    mode = 2'd2;
    issue(16'h8, 48'd1, 1'b1);
    issue(16'h8, 48'd1, 1'b0);
    issue(16'h8, 48'd2, 1'b1);
    issue(16'h8, 48'd1, 1'b1);
    wait_drained("t5");

    // mode ADDR0 and capture disable
    mode = 2'd3;
    issue(16'h0, 48'd3, 1'b1);
    issue(16'h5, 48'd3, 1'b0);
    cap_en = 1'b0;
    issue(16'h0, 48'd4, 1'b0);
    cap_en = 1'b1;
    wait_drained("t_addr0");

    // drop counter saturation
    mode = 2'd0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(16'h40 + 16'(i), 48'(i), 1'b1);
    st_addr = 16'h50; st_data = 48'h1; st_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1 st_valid = 1'b0;
    check("sat_drop", 64'(drop_cnt), 64'hFF);

    // 6: reset mid-drain discards contents and clears drop_cnt
    do_reset();
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_level", 64'(level), 64'd0);
    check("t6_drop", 64'(drop_cnt), 64'd0);
    check("t6_out_data", 64'(out_data), 64'd0);
    out_ready = 1'b1;
    issue(16'h60, 48'h77, 1'b1);
    check("t6_valid_after", 64'(out_valid), 64'd1);
    wait_drained("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
